// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared pipeline encodings for the hazard/stall controller: register index width,
// Tuse/Tnew sentinels and default MDU latencies.
package hazard_stall_ctrl_pkg;

    localparam int unsigned REG_W        = 5;
    localparam logic [1:0]  TUSE_NEVER   = 2'd3;
    localparam int unsigned MULT_CYC_DEF = 5;
    localparam int unsigned DIV_CYC_DEF  = 10;

    // RAW hazard on one source operand against the E and M destinations.
    function automatic logic raw_hit(
        input logic [REG_W-1:0] src,
        input logic [1:0]       tuse,
        input logic [REG_W-1:0] a_e,
        input logic [1:0]       tnew_e,
        input logic [REG_W-1:0] a_m,
        input logic [1:0]       tnew_m
    );
        // Tnew never exceeds 2, so TUSE_NEVER cannot stall; the explicit test only documents it
        return (src != '0) && (tuse != TUSE_NEVER) &&
               (((src == a_e) && (tnew_e > tuse)) || ((src == a_m) && (tnew_m > tuse)));
    endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Multiply/divide unit occupancy: loads the operation latency on issue in E and
// counts down to zero; a new issue always reloads.
module md_busy_counter #(
    parameter int unsigned CNT_W    = 4,
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_div,
    output logic [CNT_W-1:0] cnt,
    output logic             busy
);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= is_div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // The issue cycle itself counts as busy, giving N+1 busy cycles in total.
    assign busy = start | (cnt != '0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Decode-stage stall/flush controller: Tuse/Tnew RAW detection, MDU occupancy stall,
// pipeline enables/clears and a saturating stalled-cycle statistic.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYC = MULT_CYC_DEF,
    parameter int unsigned DIV_CYC  = DIV_CYC_DEF,
    parameter int unsigned CNT_W    = 4,
    parameter int unsigned PERF_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_W-1:0]  rs_D,
    input  logic [REG_W-1:0]  rt_D,
    input  logic [1:0]        tuse_rs_D,
    input  logic [1:0]        tuse_rt_D,
    input  logic [REG_W-1:0]  a_E,
    input  logic [1:0]        tnew_E,
    input  logic [REG_W-1:0]  a_M,
    input  logic [1:0]        tnew_M,
    input  logic              md_use_D,
    input  logic              md_start_E,
    input  logic              md_div_E,
    output logic              stall,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              id_ex_clr,
    output logic              md_busy,
    output logic [CNT_W-1:0]  md_cnt,
    output logic [PERF_W-1:0] stall_cycles
);

    logic stall_rs;
    logic stall_rt;
    logic md_stall;

    md_busy_counter #(
        .CNT_W    (CNT_W),
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC)
    ) u_md_busy_counter (
        .clk    (clk),
        .reset  (reset),
        .start  (md_start_E),
        .is_div (md_div_E),
        .cnt    (md_cnt),
        .busy   (md_busy)
    );

    always_comb begin
        stall_rs  = raw_hit(rs_D, tuse_rs_D, a_E, tnew_E, a_M, tnew_M);
        stall_rt  = raw_hit(rt_D, tuse_rt_D, a_E, tnew_E, a_M, tnew_M);
        md_stall  = md_use_D & md_busy;
        stall     = stall_rs | stall_rt | md_stall;
        pc_en     = ~stall;
        if_id_en  = ~stall;
        id_ex_clr = stall;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed scoreboard bench for hazard_stall_ctrl: stimulus pushes hand-computed
// expectations, a monitor pops and compares them each cycle just before the clock edge.
module tb_hazard_stall_ctrl;

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned PERF_W = 4;

    logic              clk;
    logic              reset;
    logic [4:0]        rs_D, rt_D, a_E, a_M;
    logic [1:0]        tuse_rs_D, tuse_rt_D, tnew_E, tnew_M;
    logic              md_use_D, md_start_E, md_div_E;
    logic              stall, pc_en, if_id_en, id_ex_clr, md_busy;
    logic [CNT_W-1:0]  md_cnt;
    logic [PERF_W-1:0] stall_cycles;

    typedef struct {
        string            name;
        logic             stall;
        logic             busy;
        logic [CNT_W-1:0] cnt;
        logic [PERF_W-1:0] sc;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    hazard_stall_ctrl #(
        .MULT_CYC (5),
        .DIV_CYC  (10),
        .CNT_W    (CNT_W),
        .PERF_W   (PERF_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rs_D         (rs_D),
        .rt_D         (rt_D),
        .tuse_rs_D    (tuse_rs_D),
        .tuse_rt_D    (tuse_rt_D),
        .a_E          (a_E),
        .tnew_E       (tnew_E),
        .a_M          (a_M),
        .tnew_M       (tnew_M),
        .md_use_D     (md_use_D),
        .md_start_E   (md_start_E),
        .md_div_E     (md_div_E),
        .stall        (stall),
        .pc_en        (pc_en),
        .if_id_en     (if_id_en),
        .id_ex_clr    (id_ex_clr),
        .md_busy      (md_busy),
        .md_cnt       (md_cnt),
        .stall_cycles (stall_cycles)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Next cycle: wait for the falling edge and return every input to its idle value.
    task automatic tick();
        @(negedge clk);
        reset      = 1'b0;
        rs_D       = 5'd0;
        rt_D       = 5'd0;
        tuse_rs_D  = 2'd3;
        tuse_rt_D  = 2'd3;
        a_E        = 5'd0;
        tnew_E     = 2'd0;
        a_M        = 5'd0;
        tnew_M     = 2'd0;
        md_use_D   = 1'b0;
        md_start_E = 1'b0;
        md_div_E   = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic s, input logic b,
                              input int c, input int sc);
        exp_t e;
        e.name  = name;
        e.stall = s;
        e.busy  = b;
        e.cnt   = CNT_W'(c);
        e.sc    = PERF_W'(sc);
        exp_q.push_back(e);
    endtask

    // Monitor: outputs are settled 3 time units after the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (stall !== e.stall || pc_en !== ~e.stall || if_id_en !== ~e.stall ||
                    id_ex_clr !== e.stall || md_busy !== e.busy || md_cnt !== e.cnt ||
                    stall_cycles !== e.sc) begin
                    n_miss++;
                    $display("FAIL %s: got stall=%b pc_en=%b if_id_en=%b id_ex_clr=%b busy=%b cnt=%0d sc=%0d, want stall=%b pc_en=%b if_id_en=%b id_ex_clr=%b busy=%b cnt=%0d sc=%0d",
                             e.name, stall, pc_en, if_id_en, id_ex_clr, md_busy, md_cnt,
                             stall_cycles, e.stall, ~e.stall, ~e.stall, e.stall, e.busy,
                             e.cnt, e.sc);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        tick(); reset = 1'b1; expect_out("reset_state", 0, 0, 0, 0);

        // Load-use through E then M
        tick(); rs_D = 9; tuse_rs_D = 0; a_E = 9; tnew_E = 2;
        expect_out("load_use_E", 1, 0, 0, 0);
        tick(); rs_D = 9; tuse_rs_D = 0; a_M = 9; tnew_M = 1;
        expect_out("load_use_M", 1, 0, 0, 1);
        tick(); rs_D = 9; tuse_rs_D = 0; a_M = 9; tnew_M = 0;
        expect_out("load_ready_M", 0, 0, 0, 2);
        tick(); rs_D = 0; tuse_rs_D = 0; a_E = 0; tnew_E = 2;
        expect_out("zero_reg", 0, 0, 0, 2);
        tick(); rs_D = 9; tuse_rs_D = 3; a_E = 9; tnew_E = 2;
        expect_out("tuse_never", 0, 0, 0, 2);
        tick(); rt_D = 10; tuse_rt_D = 1; a_M = 10; tnew_M = 2;
        expect_out("rt_hazard_M", 1, 0, 0, 2);
        tick(); rt_D = 10; tuse_rt_D = 1; a_E = 10; tnew_E = 1;
        expect_out("rt_tnew_eq_tuse", 0, 0, 0, 3);
        tick(); rs_D = 5; tuse_rs_D = 0; a_E = 5; tnew_E = 1;
        expect_out("rs_alu_E", 1, 0, 0, 3);

        // Reset clears the statistic from the first reset edge
        tick(); reset = 1'b1; expect_out("reset_pre_edge", 0, 0, 0, 4);
        tick(); reset = 1'b1; expect_out("reset_post_edge", 0, 0, 0, 0);

        // Multiply with mflo waiting in D
        tick(); md_start_E = 1; md_use_D = 1; expect_out("mult_issue", 1, 1, 0, 0);
        for (int k = 0; k < 5; k++) begin
            tick(); md_use_D = 1; expect_out("mult_busy", 1, 1, 5 - k, 1 + k);
        end
        tick(); md_use_D = 1; expect_out("mult_done", 0, 0, 0, 6);

        // Divide, reloaded by a multiply issued at md_cnt = 3
        tick(); md_start_E = 1; md_div_E = 1; expect_out("div_issue", 0, 1, 0, 6);
        for (int k = 0; k < 7; k++) begin
            tick(); expect_out("div_busy", 0, 1, 10 - k, 6);
        end
        tick(); md_start_E = 1; expect_out("mult_reload", 0, 1, 3, 6);
        tick(); expect_out("reloaded_cnt", 0, 1, 5, 6);
        tick(); md_use_D = 1; rs_D = 9; tuse_rs_D = 0; a_E = 9; tnew_E = 2;
        expect_out("data_and_md_stall", 1, 1, 4, 6);
        tick(); expect_out("single_count", 0, 1, 3, 7);

        // Reset in the middle of a divide
        tick(); md_start_E = 1; md_div_E = 1; expect_out("div2_issue", 0, 1, 2, 7);
        tick(); expect_out("div2_busy10", 0, 1, 10, 7);
        tick(); expect_out("div2_busy9", 0, 1, 9, 7);
        tick(); expect_out("div2_busy8", 0, 1, 8, 7);
        tick(); reset = 1'b1; expect_out("div2_reset_at7", 0, 1, 7, 7);
        tick(); reset = 1'b1; expect_out("div2_aborted", 0, 0, 0, 0);
        tick(); expect_out("after_reset", 0, 0, 0, 0);

        // Issue during a stall is honoured; then saturate the 4-bit statistic
        tick(); md_start_E = 1; rs_D = 9; tuse_rs_D = 0; a_E = 9; tnew_E = 2;
        expect_out("issue_while_clr", 1, 1, 0, 0);
        for (int k = 0; k < 18; k++) begin
            tick(); rs_D = 9; tuse_rs_D = 0; a_E = 9; tnew_E = 2;
            expect_out("saturate", 1, (k < 5), (k < 5) ? 5 - k : 0, (k < 14) ? 1 + k : 15);
        end
        tick(); expect_out("sat_hold", 0, 0, 0, 15);

        tick();
        tick();
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
